// File: rtl/cbus_master.sv
// rtl/cbus_master.sv - timed read/write cycle initiator for the W5300/SL811 chip bus
module cbus_master #(
  parameter int SETUP  = 1,
  parameter int STROBE = 5,
  parameter int HOLD   = 1
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic       sel,
  input  logic [9:0] addr,
  input  logic [7:0] wdata,
  input  logic       bus_free,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       busy,
  input  logic [7:0] bd_in,
  output logic [7:0] bd_out,
  output logic       bd_oe,
  output logic       w5300_cs_n,
  output logic       sl811_cs_n,
  output logic [9:0] w5300_addr,
  output logic       sl811_a0,
  output logic       bwr_n,
  output logic       brd_n
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Phase counters are loaded with width-1 and count down to zero.
  localparam logic [3:0] SETUP_N  = 4'(SETUP - 1);
  localparam logic [3:0] STROBE_N = 4'(STROBE - 1);
  localparam logic [3:0] HOLD_N   = 4'(HOLD - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic       we_q;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      ack        <= 1'b0;
      rdata      <= 8'h00;
      busy       <= 1'b0;
      bd_out     <= 8'h00;
      bd_oe      <= 1'b0;
      w5300_cs_n <= 1'b1;
      sl811_cs_n <= 1'b1;
      w5300_addr <= 10'h000;
      sl811_a0   <= 1'b0;
      bwr_n      <= 1'b1;
      brd_n      <= 1'b1;
    end else begin
      ack <= 1'b0;
      case (state)
        // The ack cycle keeps both chipselects high; a pending request is
        // taken at its closing edge, giving exactly one idle-bus cycle.
        ST_IDLE, ST_DONE: begin
          if (req && bus_free) begin
            we_q       <= we;
            w5300_cs_n <= sel;
            sl811_cs_n <= !sel;
            w5300_addr <= addr;
            sl811_a0   <= addr[0];
            if (we) begin
              bd_out <= wdata;
            end
            bd_oe <= we;
            busy  <= 1'b1;
            cnt   <= SETUP_N;
            state <= ST_SETUP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cnt == 4'd0) begin
            bwr_n <= !we_q;
            brd_n <= we_q;
            cnt   <= STROBE_N;
            state <= ST_STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt == 4'd0) begin
            bwr_n <= 1'b1;
            brd_n <= 1'b1;
            if (!we_q) begin
              rdata <= bd_in;
            end
            cnt   <= HOLD_N;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == 4'd0) begin
            w5300_cs_n <= 1'b1;
            sl811_cs_n <= 1'b1;
            bd_oe      <= 1'b0;
            ack        <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_master.sv
// tb/tb_cbus_master.sv - directed self-checking bench for cbus_master
module tb_cbus_master;

  logic       fclk = 1'b0;
  logic       rst;
  logic       req, req2, we, sel, bus_free;
  logic [9:0] addr;
  logic [7:0] wdata, bd_in;

  logic       ack, busy, bd_oe, w5300_cs_n, sl811_cs_n, sl811_a0, bwr_n, brd_n;
  logic [7:0] rdata, bd_out;
  logic [9:0] w5300_addr;
  logic       ack_2, busy_2, bd_oe_2, w5300_cs_n_2, sl811_cs_n_2, sl811_a0_2, bwr_n_2, brd_n_2;
  logic [7:0] rdata_2, bd_out_2;
  logic [9:0] w5300_addr_2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 fclk = ~fclk;

  cbus_master dut (
    .fclk(fclk), .rst(rst), .req(req), .we(we), .sel(sel), .addr(addr),
    .wdata(wdata), .bus_free(bus_free), .ack(ack), .rdata(rdata), .busy(busy),
    .bd_in(bd_in), .bd_out(bd_out), .bd_oe(bd_oe), .w5300_cs_n(w5300_cs_n),
    .sl811_cs_n(sl811_cs_n), .w5300_addr(w5300_addr), .sl811_a0(sl811_a0),
    .bwr_n(bwr_n), .brd_n(brd_n)
  );

  cbus_master #(.SETUP(2), .STROBE(1), .HOLD(3)) dut_2 (
    .fclk(fclk), .rst(rst), .req(req2), .we(we), .sel(sel), .addr(addr),
    .wdata(wdata), .bus_free(bus_free), .ack(ack_2), .rdata(rdata_2), .busy(busy_2),
    .bd_in(bd_in), .bd_out(bd_out_2), .bd_oe(bd_oe_2), .w5300_cs_n(w5300_cs_n_2),
    .sl811_cs_n(sl811_cs_n_2), .w5300_addr(w5300_addr_2), .sl811_a0(sl811_a0_2),
    .bwr_n(bwr_n_2), .brd_n(brd_n_2)
  );

  logic [6:0] ctl_1, ctl_2;
  assign ctl_1 = {w5300_cs_n, sl811_cs_n, bwr_n, brd_n, bd_oe, ack, busy};
  assign ctl_2 = {w5300_cs_n_2, sl811_cs_n_2, bwr_n_2, brd_n_2, bd_oe_2, ack_2, busy_2};

  localparam logic [6:0] CTL_RESET = 7'b1111000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One access from acceptance through the ack cycle, checked every cycle
  // against the phase widths; returns at the negedge of the ack cycle.
  task automatic trace(input int id, input int s, input int st, input int h,
                       input logic w, input logic sl, input logic [9:0] a,
                       input logic [7:0] d, input logic [7:0] bdi,
                       input int drop_at, input bit keep);
    int t;
    logic csl, strl;
    logic [6:0] exp, obs;
    t = s + st + h;
    we = w; sel = sl; addr = a; wdata = d; bd_in = bdi; bus_free = 1'b1;
    if (id == 0) req = 1'b1; else req2 = 1'b1;
    for (int k = 0; k <= t; k++) begin
      @(negedge fclk);
      csl  = (k < t);
      strl = (k >= s) && (k < s + st);
      exp  = {!(csl && !sl), !(csl && sl), !(strl && w), !(strl && !w), w && csl, k == t, csl};
      obs  = (id == 0) ? ctl_1 : ctl_2;
      check($sformatf("ctl id=%0d k=%0d", id, k), 32'(obs), 32'(exp));
      if (k == 0 || k == t - 1) begin
        check($sformatf("addr id=%0d k=%0d", id, k),
              32'((id == 0) ? w5300_addr : w5300_addr_2), 32'(a));
        check($sformatf("a0 id=%0d k=%0d", id, k),
              32'((id == 0) ? sl811_a0 : sl811_a0_2), 32'(a[0]));
        if (w) begin
          check($sformatf("bd_out id=%0d k=%0d", id, k),
                32'((id == 0) ? bd_out : bd_out_2), 32'(d));
        end
      end
      if (k == drop_at) bus_free = 1'b0;
    end
    if (!w) begin
      check($sformatf("rdata id=%0d", id), 32'((id == 0) ? rdata : rdata_2), 32'(bdi));
    end
    if (!keep) begin
      req = 1'b0;
      req2 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req2 = 1'b0; we = 1'b0; sel = 1'b0;
    addr = 10'h0; wdata = 8'h0; bd_in = 8'h0; bus_free = 1'b1;
    repeat (2) @(negedge fclk);
    check("reset ctl", 32'(ctl_1), 32'(CTL_RESET));
    check("reset ctl2", 32'(ctl_2), 32'(CTL_RESET));
    check("reset rdata", 32'(rdata), 32'h0);
    check("reset addr", 32'(w5300_addr), 32'h0);
    rst = 1'b0;
    @(negedge fclk);

    // W5300 read, then SL811 write; rdata must survive the write.
    trace(0, 1, 5, 1, 1'b0, 1'b0, 10'h2A5, 8'h00, 8'h5C, -1, 1'b0);
    @(negedge fclk);
    check("idle after read", 32'(ctl_1), 32'(CTL_RESET));
    trace(0, 1, 5, 1, 1'b1, 1'b1, 10'h001, 8'hA3, 8'hFF, -1, 1'b0);
    check("rdata kept", 32'(rdata), 32'h5C);
    @(negedge fclk);

    // bus_free gating, then bus_free dropped mid-cycle.
    req = 1'b1; bus_free = 1'b0; we = 1'b0; sel = 1'b0; addr = 10'h0F0;
    for (int i = 0; i < 10; i++) begin
      @(negedge fclk);
      check($sformatf("bf wait %0d", i), 32'(ctl_1), 32'(CTL_RESET));
    end
    trace(0, 1, 5, 1, 1'b0, 1'b0, 10'h0F0, 8'h00, 8'h96, 2, 1'b0);
    bus_free = 1'b1;
    @(negedge fclk);

    // Back-to-back with req held: second access accepted 8 cycles later.
    trace(0, 1, 5, 1, 1'b0, 1'b1, 10'h3C2, 8'h00, 8'h11, -1, 1'b1);
    trace(0, 1, 5, 1, 1'b1, 1'b0, 10'h155, 8'h7E, 8'h22, -1, 1'b0);
    @(negedge fclk);

    // Non-default timing instance.
    trace(1, 2, 1, 3, 1'b1, 1'b0, 10'h2AA, 8'h4D, 8'h00, -1, 1'b0);
    @(negedge fclk);
    trace(1, 2, 1, 3, 1'b0, 1'b1, 10'h0B3, 8'h00, 8'hE7, -1, 1'b0);
    @(negedge fclk);

    // Reset during STROBE of a W5300 write.
    we = 1'b1; sel = 1'b0; addr = 10'h155; wdata = 8'h3C; req = 1'b1;
    repeat (3) @(negedge fclk);
    check("pre-rst ctl", 32'(ctl_1), 32'(7'b0101101));
    #2 rst = 1'b1;
    #1;
    check("async rst ctl", 32'(ctl_1), 32'(CTL_RESET));
    check("async rst bd_out", 32'(bd_out), 32'h0);
    check("async rst rdata", 32'(rdata), 32'h0);
    check("async rst addr", 32'(w5300_addr), 32'h0);
    repeat (2) @(negedge fclk);
    check("rst held ctl", 32'(ctl_1), 32'(CTL_RESET));
    rst = 1'b0;
    trace(0, 1, 5, 1, 1'b1, 1'b0, 10'h155, 8'h3C, 8'h00, -1, 1'b0);
    @(negedge fclk);
    check("final idle", 32'(ctl_1), 32'(CTL_RESET));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
